// File: rtl/rv32im_pkg.sv
// Shared RV32IM core constants and types used by the register-file write arbiter.
package rv32im_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned REG_ADDR_W     = 5;
  localparam int unsigned NUM_REGS       = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StHold  = 2'd1,
    StForce = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } rf_req_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-destination mask for in-flight MUL/DIV ops and the decode hazard compare.
module reg_scoreboard
  import rv32im_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_addr,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  hazard
);

  logic [NUM_REGS-1:0] pending_q, pending_d;

  // Clear is applied first so a same-cycle issue to that register wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_valid) begin
      pending_d[clr_addr] = 1'b0;
    end
    if (issue_valid) begin
      pending_d[issue_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_comb begin
    hazard = pending_q[rs1_addr] | pending_q[rs2_addr] | pending_q[rd_addr] |
             (issue_valid & pending_q[issue_addr]);
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Single-port register-file write arbiter between in-order writeback and MUL/DIV results.
module reg_write_arbiter #(
  parameter int unsigned STARVE_MAX = rv32im_pkg::STARVE_MAX_DEF
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              WB_VALID,
  input  logic [rv32im_pkg::REG_ADDR_W-1:0] WB_ADDR,
  input  logic [rv32im_pkg::XLEN-1:0]       WB_DATA,
  input  logic                              MD_VALID,
  input  logic [rv32im_pkg::REG_ADDR_W-1:0] MD_ADDR,
  input  logic [rv32im_pkg::XLEN-1:0]       MD_DATA,
  output logic                              MD_READY,
  input  logic                              ISSUE_VALID,
  input  logic [rv32im_pkg::REG_ADDR_W-1:0] ISSUE_ADDR,
  input  logic [rv32im_pkg::REG_ADDR_W-1:0] RS1_ADDR,
  input  logic [rv32im_pkg::REG_ADDR_W-1:0] RS2_ADDR,
  input  logic [rv32im_pkg::REG_ADDR_W-1:0] RD_ADDR,
  output logic                              HAZARD_STALL,
  output logic                              WB_STALL,
  output logic                              RF_WRITE,
  output logic [rv32im_pkg::REG_ADDR_W-1:0] RF_ADDRW,
  output logic [rv32im_pkg::XLEN-1:0]       RF_IN
);

  import rv32im_pkg::*;

  localparam int unsigned    CntW   = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            buf_valid_q;
  rf_req_t         buf_q;

  logic            grant;
  logic            grant_md;
  rf_req_t         grant_req;
  logic            buf_load;
  logic            buf_clr;
  logic            md_ready_c;
  logic            wb_stall_c;

  logic                  rf_write_q;
  logic                  rf_md_q;
  logic [REG_ADDR_W-1:0] rf_addr_q;
  logic [XLEN-1:0]       rf_data_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant      = 1'b0;
    grant_md   = 1'b0;
    grant_req  = '0;
    buf_load   = 1'b0;
    buf_clr    = 1'b0;
    md_ready_c = 1'b0;
    wb_stall_c = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (WB_VALID) begin
          grant     = 1'b1;
          grant_req = '{addr: WB_ADDR, data: WB_DATA};
          if (MD_VALID) begin
            md_ready_c = 1'b1;
            buf_load   = 1'b1;
            cnt_d      = '0;
            state_d    = StHold;
          end
        end else if (MD_VALID) begin
          grant      = 1'b1;
          grant_md   = 1'b1;
          grant_req  = '{addr: MD_ADDR, data: MD_DATA};
          md_ready_c = 1'b1;
        end
      end

      StHold: begin
        if (!WB_VALID) begin
          grant     = buf_valid_q;
          grant_md  = buf_valid_q;
          grant_req = buf_q;
          buf_clr   = 1'b1;
          cnt_d     = '0;
          state_d   = StIdle;
        end else if (WB_ADDR == buf_q.addr) begin
          // Buffered result is older: hold WB back until the buffer lands.
          wb_stall_c = 1'b1;
          state_d    = StForce;
        end else begin
          grant     = 1'b1;
          grant_req = '{addr: WB_ADDR, data: WB_DATA};
          if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
          end
          if (cnt_d == CntMax) begin
            state_d = StForce;
          end
        end
      end

      StForce: begin
        grant      = buf_valid_q;
        grant_md   = buf_valid_q;
        grant_req  = buf_q;
        buf_clr    = 1'b1;
        wb_stall_c = 1'b1;
        cnt_d      = '0;
        state_d    = StIdle;
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_q       <= '0;
      rf_write_q  <= 1'b0;
      rf_md_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (buf_load) begin
        buf_valid_q <= 1'b1;
        buf_q       <= '{addr: MD_ADDR, data: MD_DATA};
      end else if (buf_clr) begin
        buf_valid_q <= 1'b0;
      end
      // x0 is hardwired: the grant still consumes the slot but never writes.
      rf_write_q <= grant && (grant_req.addr != '0);
      rf_md_q    <= grant && grant_md && (grant_req.addr != '0);
      rf_addr_q  <= grant ? grant_req.addr : '0;
      rf_data_q  <= grant ? grant_req.data : '0;
    end
  end

  // Pending bit drops only once the MD result is actually on the write port.
  reg_scoreboard u_reg_scoreboard (
    .CLK        (CLK),
    .RESET      (RESET),
    .issue_valid(ISSUE_VALID),
    .issue_addr (ISSUE_ADDR),
    .clr_valid  (rf_md_q),
    .clr_addr   (rf_addr_q),
    .rs1_addr   (RS1_ADDR),
    .rs2_addr   (RS2_ADDR),
    .rd_addr    (RD_ADDR),
    .hazard     (HAZARD_STALL)
  );

  always_comb begin
    MD_READY = md_ready_c & ~RESET;
    WB_STALL = wb_stall_c & ~RESET;
    RF_WRITE = rf_write_q;
    RF_ADDRW = rf_addr_q;
    RF_IN    = rf_data_q;
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a queue of expected register-file writes.
module tb_reg_write_arbiter;

  logic        CLK;
  logic        RESET;
  logic        WB_VALID;
  logic [4:0]  WB_ADDR;
  logic [31:0] WB_DATA;
  logic        MD_VALID;
  logic [4:0]  MD_ADDR;
  logic [31:0] MD_DATA;
  logic        MD_READY;
  logic        ISSUE_VALID;
  logic [4:0]  ISSUE_ADDR;
  logic [4:0]  RS1_ADDR;
  logic [4:0]  RS2_ADDR;
  logic [4:0]  RD_ADDR;
  logic        HAZARD_STALL;
  logic        WB_STALL;
  logic        RF_WRITE;
  logic [4:0]  RF_ADDRW;
  logic [31:0] RF_IN;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  reg_write_arbiter #(.STARVE_MAX(4)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .WB_VALID    (WB_VALID),
    .WB_ADDR     (WB_ADDR),
    .WB_DATA     (WB_DATA),
    .MD_VALID    (MD_VALID),
    .MD_ADDR     (MD_ADDR),
    .MD_DATA     (MD_DATA),
    .MD_READY    (MD_READY),
    .ISSUE_VALID (ISSUE_VALID),
    .ISSUE_ADDR  (ISSUE_ADDR),
    .RS1_ADDR    (RS1_ADDR),
    .RS2_ADDR    (RS2_ADDR),
    .RD_ADDR     (RD_ADDR),
    .HAZARD_STALL(HAZARD_STALL),
    .WB_STALL    (WB_STALL),
    .RF_WRITE    (RF_WRITE),
    .RF_ADDRW    (RF_ADDRW),
    .RF_IN       (RF_IN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    WB_VALID    = 1'b0;
    WB_ADDR     = '0;
    WB_DATA     = '0;
    MD_VALID    = 1'b0;
    MD_ADDR     = '0;
    MD_DATA     = '0;
    ISSUE_VALID = 1'b0;
    ISSUE_ADDR  = '0;
    RS1_ADDR    = '0;
    RS2_ADDR    = '0;
    RD_ADDR     = '0;
  endtask

  // Inputs are already driven; check combinational outputs, then the registered write.
  task automatic step(input string tag, input logic mdr, input logic stl, input logic haz,
                      input logic we, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    #2;
    chk({tag, ".md_ready"}, 32'(MD_READY), 32'(mdr));
    chk({tag, ".wb_stall"}, 32'(WB_STALL), 32'(stl));
    chk({tag, ".hazard"}, 32'(HAZARD_STALL), 32'(haz));
    e.we   = we;
    e.addr = a;
    e.data = d;
    e.tag  = tag;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    chk({e.tag, ".rf_write"}, 32'(RF_WRITE), 32'(e.we));
    if (e.we) begin
      chk({e.tag, ".rf_addrw"}, 32'(RF_ADDRW), 32'(e.addr));
      chk({e.tag, ".rf_in"}, RF_IN, e.data);
    end
  endtask

  initial begin
    idle();
    RESET    = 1'b1;
    MD_VALID = 1'b1;
    #3;
    chk("reset.rf_write", 32'(RF_WRITE), 32'h0);
    chk("reset.rf_addrw", 32'(RF_ADDRW), 32'h0);
    chk("reset.rf_in", RF_IN, 32'h0);
    chk("reset.md_ready", 32'(MD_READY), 32'h0);
    chk("reset.wb_stall", 32'(WB_STALL), 32'h0);
    chk("reset.hazard", 32'(HAZARD_STALL), 32'h0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    idle();

    // Lone writeback
    WB_VALID = 1'b1; WB_ADDR = 5'd5; WB_DATA = 32'hDEADBEEF;
    step("wb_only", 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);

    // x0 is never written
    idle(); WB_VALID = 1'b1; WB_ADDR = 5'd0; WB_DATA = 32'hFFFFFFFF;
    step("wb_x0", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // Simultaneous WB and MD: WB first, buffered MD on the next idle cycle
    idle(); WB_VALID = 1'b1; WB_ADDR = 5'd3; WB_DATA = 32'h11;
    MD_VALID = 1'b1; MD_ADDR = 5'd7; MD_DATA = 32'h22;
    step("both", 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h11);
    idle();
    step("drain", 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h22);

    // Lone MD result
    idle(); MD_VALID = 1'b1; MD_ADDR = 5'd12; MD_DATA = 32'hAB;
    step("md_only", 1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 32'hAB);

    // Starvation: x9 pending, buffered behind four WB writes, then forced
    idle(); ISSUE_VALID = 1'b1; ISSUE_ADDR = 5'd9;
    step("issue9", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    idle(); RS1_ADDR = 5'd9;
    step("raw9", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    idle(); RS1_ADDR = 5'd9; WB_VALID = 1'b1; WB_ADDR = 5'd1; WB_DATA = 32'h100;
    MD_VALID = 1'b1; MD_ADDR = 5'd9; MD_DATA = 32'h99;
    step("starve_cap", 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h100);
    for (int i = 0; i < 4; i++) begin
      idle(); RS1_ADDR = 5'd9; WB_VALID = 1'b1;
      WB_ADDR = 5'(2 + i); WB_DATA = 32'h200 + 32'(i);
      MD_VALID = 1'b1; MD_ADDR = 5'd30; MD_DATA = 32'h3030;
      step($sformatf("hold%0d", i), 1'b0, 1'b0, 1'b1, 1'b1, 5'(2 + i), 32'h200 + 32'(i));
    end
    idle(); RS1_ADDR = 5'd9; WB_VALID = 1'b1; WB_ADDR = 5'd6; WB_DATA = 32'h600;
    step("force", 1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h99);
    step("after_force", 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 32'h600);
    idle(); RS1_ADDR = 5'd9;
    step("raw9_clear", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // Same-address collision in HOLD: buffer lands before the WB
    idle(); WB_VALID = 1'b1; WB_ADDR = 5'd13; WB_DATA = 32'h13;
    MD_VALID = 1'b1; MD_ADDR = 5'd14; MD_DATA = 32'h14;
    step("coll_cap", 1'b1, 1'b0, 1'b0, 1'b1, 5'd13, 32'h13);
    idle(); WB_VALID = 1'b1; WB_ADDR = 5'd14; WB_DATA = 32'h55;
    step("coll_hit", 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    step("coll_force", 1'b0, 1'b1, 1'b0, 1'b1, 5'd14, 32'h14);
    step("coll_wb", 1'b0, 1'b0, 1'b0, 1'b1, 5'd14, 32'h55);

    // Issue to x20 in the same cycle its MD write clears it: set wins
    idle(); ISSUE_VALID = 1'b1; ISSUE_ADDR = 5'd20;
    step("issue20", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    idle(); MD_VALID = 1'b1; MD_ADDR = 5'd20; MD_DATA = 32'h20;
    step("md20", 1'b1, 1'b0, 1'b0, 1'b1, 5'd20, 32'h20);
    idle(); ISSUE_VALID = 1'b1; ISSUE_ADDR = 5'd20;
    step("reissue20", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    idle(); RS1_ADDR = 5'd20;
    step("set_wins", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);

    // Reset mid-HOLD with a valid buffer
    idle(); WB_VALID = 1'b1; WB_ADDR = 5'd15; WB_DATA = 32'h15;
    MD_VALID = 1'b1; MD_ADDR = 5'd16; MD_DATA = 32'h66;
    step("rst_cap", 1'b1, 1'b0, 1'b0, 1'b1, 5'd15, 32'h15);
    idle(); MD_VALID = 1'b1; MD_ADDR = 5'd17; RS1_ADDR = 5'd20;
    RESET = 1'b1;
    #1;
    chk("midrst.rf_write", 32'(RF_WRITE), 32'h0);
    chk("midrst.rf_addrw", 32'(RF_ADDRW), 32'h0);
    chk("midrst.rf_in", RF_IN, 32'h0);
    chk("midrst.md_ready", 32'(MD_READY), 32'h0);
    chk("midrst.hazard", 32'(HAZARD_STALL), 32'h0);
    @(posedge CLK);
    #1;
    chk("midrst.hold_low", 32'(RF_WRITE), 32'h0);
    RESET = 1'b0;
    idle(); RS1_ADDR = 5'd20;
    step("post_rst0", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    idle();
    step("post_rst1", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
